fp16_square: RTL and testbench
==============================

FP16_SQUARE -- requirements
Module: fp16_square

Interface
REQ-001 SHALL have parameter BITS_PER_CYCLE, default 1, giving multiplier bits retired per CALC cycle; legal values are 1 and 2.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: operand a is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept an operand.
REQ-006 SHALL have port a, input, 16 bits: IEEE 754 half-precision operand.
REQ-007 SHALL have port out_valid, output, 1 bit: result is valid.
REQ-008 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-009 SHALL have port result, output, 16 bits: half-precision a*a.

Function
REQ-010 SHALL use the FSM states IDLE, CALC, NORM and DONE, with a single operation outstanding at a time.
REQ-011 SHALL drive in_ready=1 only in IDLE, and SHALL accept an operand on any rising edge where in_valid && in_ready.
REQ-012 SHALL, on accept of a special operand, go IDLE->DONE, with out_valid high 1 cycle after the accepting edge.
REQ-013 SHALL, on accept of a normal operand, go IDLE->CALC, spend N=ceil(11/BITS_PER_CYCLE) cycles in CALC, then NORM for 1 cycle, then DONE.
REQ-014 SHALL, for a normal operand, raise out_valid N+2 cycles after the accepting edge: 13 cycles for BITS_PER_CYCLE=1, 8 cycles for BITS_PER_CYCLE=2.
REQ-015 SHALL form the product in CALC by iterative shift-add of the 11-bit significand {1,mant} with itself into a 22-bit accumulator.
REQ-016 SHALL always give a result sign of 0, including for negative inputs and -0.
REQ-017 SHALL compute the unbiased exponent as 2*(exp_a-15), plus 1 if product bit 21 is set, then re-bias by 15, using at least 7-bit signed arithmetic.
REQ-018 SHALL round the significand in NORM to nearest even using guard and sticky bits, and a rounding carry SHALL increment the exponent.
REQ-019 SHALL, when the biased exponent is >= 31 after rounding, return 16'h7C00.
REQ-020 SHALL return 16'h7E01 for a NaN input.
REQ-021 SHALL return 16'h7C00 for a +/-Inf input.
REQ-022 SHALL return 16'h0000 for a +/-0 input.
REQ-023 SHALL return 16'h0000 for any subnormal input, since its square is below half of the minimum subnormal.
REQ-024 SHALL handle a biased result exponent <= 0 per the Configuration section.
REQ-025 SHALL hold out_valid and result stable in DONE while out_ready=0.
REQ-026 SHALL go DONE->IDLE when out_ready=1, and SHALL not accept a new operand in that same cycle, since in_ready=0 in DONE.
REQ-027 SHALL ignore in_valid and a outside IDLE.

Reset
REQ-028 SHALL, while rst_n=0 at a rising edge, go to IDLE, clear the accumulator and operand registers, and drive in_ready=1, out_valid=0 and result=16'h0000 from the following cycle.
REQ-029 SHALL, on reset during CALC, NORM or DONE, abort the operation, and SHALL never present its result.

Configuration
REQ-030 SHALL, when FP16_SQUARE_SUBNORM_EN is defined, produce subnormal results for biased exponents <= 0 by right-shifting the significand by (1-exp) with round-to-nearest-even, including rounding up into the minimum normal 16'h0400.
REQ-031 SHALL, when FP16_SQUARE_SUBNORM_EN is undefined, flush any result with a biased exponent <= 0 after rounding to 16'h0000.

Verification
REQ-032 SHALL cover: a=16'h3C00 with BITS_PER_CYCLE=1 -> result 16'h3C00, out_valid 13 cycles after accept, in_ready low throughout.
REQ-033 SHALL cover: a=16'h4000 -> 16'h4400, then a=16'hC200 -> 16'h4880, and a=16'h5C00 -> 16'h7C00 overflow.
REQ-034 SHALL cover: a=16'h7E00 -> 16'h7E01 after 1 cycle, and a=16'hFC00 -> 16'h7C00, a=16'h8000 -> 16'h0000, a=16'h0200 -> 16'h0000.
REQ-035 SHALL cover: a=16'h1400 (2^-10) -> 16'h0010 with FP16_SQUARE_SUBNORM_EN defined, and 16'h0000 without it.
REQ-036 SHALL cover: out_ready held low 5 cycles in DONE -> result stable, out_valid high, in_ready low, with in_valid pulses ignored.
REQ-037 SHALL cover: rst_n low for 1 cycle mid-CALC -> next cycle in_ready=1, out_valid=0, result=16'h0000, and a subsequent a=16'h3C00 completes normally.

Source files
------------

// File: rtl/fp16_square_if.sv
// fp16_square_if -- handshake bundle for the fp16_square block.
//   in_valid  : operand a is valid             (master -> slave)
//   in_ready  : block can accept an operand    (slave  -> master)
//   a         : IEEE 754 half-precision operand (master -> slave)
//   out_valid : result is valid                (slave  -> master)
//   out_ready : consumer accepts the result    (master -> slave)
//   result    : half-precision a*a             (slave  -> master)
interface fp16_square_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;

  modport master (
    output in_valid,
    output a,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  result
  );

  modport slave (
    input  in_valid,
    input  a,
    input  out_ready,
    output in_ready,
    output out_valid,
    output result
  );
endinterface

// File: rtl/fp16_square.sv
// fp16_square -- iterative half-precision squarer (result = a*a, sign always 0).
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : fp16_square_if.slave (in_valid/in_ready/a, out_valid/out_ready/result)
// Parameter BITS_PER_CYCLE (1 or 2): multiplier bits retired per CALC cycle.
// Optional feature: define FP16_SQUARE_SUBNORM_EN to produce subnormal results;
// otherwise results whose rounded biased exponent is <= 0 flush to +0.
module fp16_square #(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input logic        clk,
  input logic        rst_n,
  fp16_square_if.slave bus
);

  localparam int unsigned NSteps = (11 + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
  localparam int unsigned MplW   = NSteps * BITS_PER_CYCLE;

  typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_e;

  state_e            r_state;
  logic [21:0]       r_acc;
  logic [21:0]       r_mcand;
  logic [MplW-1:0]   r_mplier;
  logic [3:0]        r_cnt;
  logic [4:0]        r_exp;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [15:0]       r_result;

  logic [21:0]       w_addend;
  logic              w_p21;
  logic [20:0]       w_frac;
  logic signed [7:0] w_exp_pre;
  logic              w_up;
  logic [17:0]       w_em;
  logic signed [7:0] w_exp_rnd;
  logic [15:0]       w_norm_result;
  logic [10:0]       w_sig;
  logic              w_special;

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;

  assign w_sig     = {1'b1, bus.a[9:0]};
  assign w_special = (bus.a[14:10] == 5'h1F) || (bus.a[14:10] == 5'h00);

  // Partial products for the multiplier bits retired this cycle.
  always_comb begin
    w_addend = '0;
    for (int j = 0; j < int'(BITS_PER_CYCLE); j++) begin
      if (r_mplier[j]) w_addend = w_addend + (r_mcand << j);
    end
  end

  // Normalise so the leading one sits just above w_frac[20].
  assign w_p21     = r_acc[21];
  assign w_frac    = w_p21 ? r_acc[20:0] : {r_acc[19:0], 1'b0};
  // 2*(e-15) + p21 + 15 == 2e - 15 + p21
  assign w_exp_pre = 8'({2'b00, r_exp, 1'b0}) - 8'sd15 + 8'({7'd0, w_p21});
  assign w_up      = w_frac[10] & ((|w_frac[9:0]) | w_frac[11]);
  // Rounding carry out of the mantissa ripples straight into the exponent.
  assign w_em      = {w_exp_pre, w_frac[20:11]} + {17'd0, w_up};
  assign w_exp_rnd = w_em[17:10];

`ifdef FP16_SQUARE_SUBNORM_EN
  logic [3:0]  w_sh;
  logic [37:0] w_wide;
  logic        w_sub_up;
  logic [15:0] w_sub_result;

  assign w_sh         = 4'(8'sd1 - w_exp_pre);
  assign w_wide       = {1'b1, w_frac, 16'd0} >> w_sh;
  assign w_sub_up     = w_wide[26] & ((|w_wide[25:0]) | w_wide[27]);
  // A carry out of bit 9 lands in the exponent field, giving 16'h0400.
  assign w_sub_result = {6'd0, w_wide[36:27]} + {15'd0, w_sub_up};

  always_comb begin
    w_norm_result = {1'b0, w_exp_rnd[4:0], w_em[9:0]};
    if (w_exp_pre <= 8'sd0)       w_norm_result = w_sub_result;
    else if (w_exp_rnd >= 8'sd31) w_norm_result = 16'h7C00;
  end
`else
  always_comb begin
    w_norm_result = {1'b0, w_exp_rnd[4:0], w_em[9:0]};
    if (w_exp_rnd >= 8'sd31)     w_norm_result = 16'h7C00;
    else if (w_exp_rnd <= 8'sd0) w_norm_result = 16'h0000;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
      r_exp       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= 16'h0000;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_in_ready <= 1'b0;
            if (w_special) begin
              // Zero and subnormal inputs square to +0; NaN/Inf map to fixed codes.
              if (bus.a[14:10] == 5'h1F) begin
                r_result <= (|bus.a[9:0]) ? 16'h7E01 : 16'h7C00;
              end else begin
                r_result <= 16'h0000;
              end
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_exp    <= bus.a[14:10];
              r_mcand  <= {11'd0, w_sig};
              r_mplier <= MplW'(w_sig);
              r_acc    <= '0;
              r_cnt    <= '0;
              r_state  <= CALC;
            end
          end
        end
        CALC: begin
          r_acc    <= r_acc + w_addend;
          r_mcand  <= r_mcand << BITS_PER_CYCLE;
          r_mplier <= r_mplier >> BITS_PER_CYCLE;
          r_cnt    <= r_cnt + 4'd1;
          if (r_cnt == 4'(NSteps - 1)) r_state <= NORM;
        end
        NORM: begin
          r_result    <= w_norm_result;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_square.sv
module tb_fp16_square;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fp16_square_if if1 ();
  fp16_square_if if2 ();

  fp16_square #(.BITS_PER_CYCLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  fp16_square #(.BITS_PER_CYCLE(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic f_ov(input bit sel);
    return sel ? if2.out_valid : if1.out_valid;
  endfunction

  function automatic logic f_ir(input bit sel);
    return sel ? if2.in_ready : if1.in_ready;
  endfunction

  function automatic logic [15:0] f_res(input bit sel);
    return sel ? if2.result : if1.result;
  endfunction

  task automatic drive_in(input bit sel, input logic v, input logic [15:0] op);
    if (sel) begin
      if2.in_valid = v;
      if2.a        = op;
    end else begin
      if1.in_valid = v;
      if1.a        = op;
    end
  endtask

  task automatic drive_ordy(input bit sel, input logic v);
    if (sel) if2.out_ready = v;
    else     if1.out_ready = v;
  endtask

  // Latency counts cycles after the accepting edge; cycle 1 is the one right after it.
  task automatic run_op(input bit sel, input logic [15:0] op, input logic [15:0] exp_res,
                        input int exp_lat, input int stall, input string tag);
    int lat;
    bit busy_bad;
    @(negedge clk);
    drive_in(sel, 1'b1, op);
    @(posedge clk);
    #1;
    drive_in(sel, 1'b0, 16'hA5A5);
    lat      = 1;
    busy_bad = 1'b0;
    while (!f_ov(sel) && lat < 40) begin
      if (f_ir(sel)) busy_bad = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, {16'd0, f_res(sel)}, {16'd0, exp_res});
    check({tag, "_busy"}, {31'd0, busy_bad}, 32'd0);
    check({tag, "_rdy_done"}, {31'd0, f_ir(sel)}, 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      drive_in(sel, i[0] ? 1'b0 : 1'b1, 16'h3C00);
      @(posedge clk);
      #1;
      check({tag, "_stall"}, {14'd0, f_ov(sel), f_ir(sel), f_res(sel)},
            {14'd0, 1'b1, 1'b0, exp_res});
    end
    @(negedge clk);
    drive_in(sel, 1'b0, 16'h0000);
    drive_ordy(sel, 1'b1);
    @(posedge clk);
    #1;
    check({tag, "_release"}, {30'd0, f_ov(sel), f_ir(sel)}, {30'd0, 2'b01});
    @(negedge clk);
    drive_ordy(sel, 1'b0);
  endtask

  logic [15:0] exp_sub;
  bit          leak;

  initial begin
    rst_n = 1'b0;
    if1.in_valid = 1'b0; if1.a = 16'h0000; if1.out_ready = 1'b0;
    if2.in_valid = 1'b0; if2.a = 16'h0000; if2.out_ready = 1'b0;
`ifdef FP16_SQUARE_SUBNORM_EN
    exp_sub = 16'h0010;
`else
    exp_sub = 16'h0000;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset1", {14'd0, if1.in_ready, if1.out_valid, if1.result}, {14'd0, 2'b10, 16'h0});
    check("reset2", {14'd0, if2.in_ready, if2.out_valid, if2.result}, {14'd0, 2'b10, 16'h0});
    @(negedge clk);
    rst_n = 1'b1;

    // BITS_PER_CYCLE=1: normal operands take 13 cycles, specials 1.
    run_op(1'b0, 16'h3C00, 16'h3C00, 13, 0, "one");
    run_op(1'b0, 16'h4000, 16'h4400, 13, 0, "two");
    run_op(1'b0, 16'hC200, 16'h4880, 13, 0, "neg3");
    run_op(1'b0, 16'h5C00, 16'h7C00, 13, 0, "ovf256");
    run_op(1'b0, 16'h3C4C, 16'h3C9E, 13, 0, "rnd_up");
    run_op(1'b0, 16'h7BFF, 16'h7C00, 13, 0, "ovf_max");
    run_op(1'b0, 16'h7E00, 16'h7E01, 1,  0, "nan");
    run_op(1'b0, 16'hFC00, 16'h7C00, 1,  0, "ninf");
    run_op(1'b0, 16'h8000, 16'h0000, 1,  0, "nzero");
    run_op(1'b0, 16'h0200, 16'h0000, 1,  0, "subn_in");
    run_op(1'b0, 16'h1400, exp_sub,  13, 0, "tiny");
    run_op(1'b0, 16'h3E00, 16'h4080, 13, 5, "stall");
    run_op(1'b0, 16'h4000, 16'h4400, 13, 0, "after_stall");

    // Reset in the middle of CALC must abort the operation.
    @(negedge clk);
    drive_in(1'b0, 1'b1, 16'h4000);
    @(posedge clk);
    #1;
    drive_in(1'b0, 1'b0, 16'h0000);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_reset", {14'd0, if1.in_ready, if1.out_valid, if1.result}, {14'd0, 2'b10, 16'h0});
    @(negedge clk);
    rst_n = 1'b1;
    leak = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (if1.out_valid || !if1.in_ready) leak = 1'b1;
    end
    check("abort_quiet", {31'd0, leak}, 32'd0);
    run_op(1'b0, 16'h3C00, 16'h3C00, 13, 0, "post_reset");

    // BITS_PER_CYCLE=2: normal operands take 8 cycles.
    run_op(1'b1, 16'h3C00, 16'h3C00, 8, 0, "b2_one");
    run_op(1'b1, 16'hC200, 16'h4880, 8, 0, "b2_neg3");
    run_op(1'b1, 16'h3C4C, 16'h3C9E, 8, 0, "b2_rnd_up");
    run_op(1'b1, 16'h7C00, 16'h7C00, 1, 0, "b2_inf");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
